// File: rtl/level_fifo.sv
// ---------------------------------------------------------------------------
// level_fifo: single-clock first-word-fall-through FIFO with a registered
// occupancy count and almost-full / almost-empty threshold flags.
//
// Parameters
//   ASIZE    : address bits, capacity is 2**ASIZE entries (all usable)
//   DSIZE    : data width
//   AF_LEVEL : almost_full asserts when level >= AF_LEVEL (1..2**ASIZE)
//   AE_LEVEL : almost_empty asserts when level <= AE_LEVEL (0..2**ASIZE-1)
//
// Ports
//   clk, rst_n            : clock (rising edge), async active-low reset
//   clear_n               : synchronous active-low clear (beats handshakes)
//   wr_data/valid/ready   : write handshake, wr_ready = !full
//   rd_data/valid/ready   : read handshake, rd_valid = !empty, rd_data
//                           shows the head entry combinationally
//   level                 : current occupancy, 0..2**ASIZE
//   almost_full/empty     : threshold flags from the registered level
//   ovf_flag, ovf_count   : only with LEVEL_FIFO_OVF_MON_EN defined; sticky
//                           flag and saturating count of refused writes
//
// Optional feature macro: LEVEL_FIFO_OVF_MON_EN
// ---------------------------------------------------------------------------
module level_fifo #(
  parameter int ASIZE    = 5,
  parameter int DSIZE    = 32,
  parameter int AF_LEVEL = 2**ASIZE - 4,
  parameter int AE_LEVEL = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_n,
  input  logic [DSIZE-1:0] wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [DSIZE-1:0] rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [ASIZE:0]   level,
  output logic             almost_full,
`ifdef LEVEL_FIFO_OVF_MON_EN
  output logic             almost_empty,
  output logic             ovf_flag,
  output logic [7:0]       ovf_count
`else
  output logic             almost_empty
`endif
);

  localparam int             DEPTH  = 2**ASIZE;
  localparam logic [ASIZE:0] ONE    = (ASIZE+1)'(1);
  localparam logic [ASIZE:0] AF_LVL = (ASIZE+1)'(AF_LEVEL);
  localparam logic [ASIZE:0] AE_LVL = (ASIZE+1)'(AE_LEVEL);

  logic [ASIZE:0]   wr_ptr_q, wr_ptr_d;
  logic [ASIZE:0]   rd_ptr_q, rd_ptr_d;
  logic [ASIZE:0]   level_q,  level_d;
  logic [DSIZE-1:0] mem_q [DEPTH];

  logic full, empty, do_wr, do_rd;

  // Extra pointer MSB distinguishes full from empty when the addresses match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ASIZE-1:0] == rd_ptr_q[ASIZE-1:0]) &&
                 (wr_ptr_q[ASIZE] != rd_ptr_q[ASIZE]);

  assign wr_ready     = !full;
  assign rd_valid     = !empty;
  assign rd_data      = mem_q[rd_ptr_q[ASIZE-1:0]];
  assign level        = level_q;
  assign almost_full  = (level_q >= AF_LVL);
  assign almost_empty = (level_q <= AE_LVL);

  // Clear discards the write of its cycle, so it also gates the memory.
  assign do_wr = wr_valid && !full  && clear_n;
  assign do_rd = rd_ready && !empty && clear_n;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (!clear_n) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + ONE;
      if (do_rd) rd_ptr_d = rd_ptr_q + ONE;
      unique case ({do_wr, do_rd})
        2'b10:   level_d = level_q + ONE;
        2'b01:   level_d = level_q - ONE;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: the storage array has no reset or clear; empty/full come from the
  // pointers alone, so stale contents are never observable as valid data.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[ASIZE-1:0]] <= wr_data;
  end

`ifdef LEVEL_FIFO_OVF_MON_EN
  logic       ovf_flag_q,  ovf_flag_d;
  logic [7:0] ovf_count_q, ovf_count_d;

  // A refused write is any cycle presenting wr_valid while full.
  always_comb begin
    ovf_flag_d  = ovf_flag_q;
    ovf_count_d = ovf_count_q;
    if (!clear_n) begin
      ovf_flag_d  = 1'b0;
      ovf_count_d = '0;
    end else if (wr_valid && full) begin
      ovf_flag_d = 1'b1;
      if (ovf_count_q != 8'hFF) ovf_count_d = ovf_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_flag_q  <= 1'b0;
      ovf_count_q <= '0;
    end else begin
      ovf_flag_q  <= ovf_flag_d;
      ovf_count_q <= ovf_count_d;
    end
  end

  assign ovf_flag  = ovf_flag_q;
  assign ovf_count = ovf_count_q;
`endif

endmodule

// File: tb/tb_level_fifo.sv
// ---------------------------------------------------------------------------
// tb_level_fifo: randomized and directed bench for level_fifo (ASIZE=3,
// DSIZE=8, AF_LEVEL=6, AE_LEVEL=1) against a queue-based reference model.
// Inputs change after the falling edge; outputs are compared just before
// each rising edge. Overflow-monitor checks are compiled in together with
// LEVEL_FIFO_OVF_MON_EN.
// ---------------------------------------------------------------------------
module tb_level_fifo;

  localparam int ASIZE = 3;
  localparam int DSIZE = 8;
  localparam int CAP   = 2**ASIZE;
  localparam int AF    = 6;
  localparam int AE    = 1;

  logic             clk = 1'b0;
  logic             rst_n, clear_n;
  logic [DSIZE-1:0] wr_data, rd_data;
  logic             wr_valid, wr_ready, rd_valid, rd_ready;
  logic [ASIZE:0]   level;
  logic             almost_full, almost_empty;
`ifdef LEVEL_FIFO_OVF_MON_EN
  logic             ovf_flag;
  logic [7:0]       ovf_count;
`endif

  level_fifo #(.ASIZE(ASIZE), .DSIZE(DSIZE), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_n      (clear_n),
    .wr_data      (wr_data),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .level        (level),
    .almost_full  (almost_full),
`ifdef LEVEL_FIFO_OVF_MON_EN
    .almost_empty (almost_empty),
    .ovf_flag     (ovf_flag),
    .ovf_count    (ovf_count)
`else
    .almost_empty (almost_empty)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: contents as a queue, plus overflow bookkeeping.
  logic [DSIZE-1:0] mq[$];
  int               m_ovf_cnt;
  bit               m_ovf_flag;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf_cnt  = 0;
    m_ovf_flag = 1'b0;
  endtask

  // Applies the handshake rules to the inputs sampled at a rising edge.
  task automatic model_edge();
    bit w, r;
    if (!clear_n) begin
      model_reset();
    end else begin
      w = wr_valid && (mq.size() < CAP);
      r = rd_ready && (mq.size() > 0);
      if (wr_valid && mq.size() == CAP) begin
        m_ovf_flag = 1'b1;
        if (m_ovf_cnt < 255) m_ovf_cnt++;
      end
      if (r) void'(mq.pop_front());
      if (w) mq.push_back(wr_data);
    end
  endtask

  task automatic check_outputs();
    int n;
    n = mq.size();
    check("wr_ready",     wr_ready,     (n < CAP));
    check("rd_valid",     rd_valid,     (n > 0));
    check("level",        level,        n);
    check("almost_full",  almost_full,  (n >= AF));
    check("almost_empty", almost_empty, (n <= AE));
    if (n > 0) check("rd_data", rd_data, mq[0]);
`ifdef LEVEL_FIFO_OVF_MON_EN
    check("ovf_flag",  ovf_flag,  m_ovf_flag);
    check("ovf_count", ovf_count, m_ovf_cnt);
`endif
  endtask

  // Entered just after a falling edge: set inputs, compare, take the edge.
  task automatic drive(input bit w, input logic [DSIZE-1:0] d, input bit r, input bit c);
    wr_valid = w;
    wr_data  = d;
    rd_ready = r;
    clear_n  = c;
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; clear_n = 1'b1; wr_valid = 1'b0; rd_ready = 1'b0; wr_data = '0;
    model_reset();
    #1;
    check("rst_wr_ready", wr_ready, 1'b1);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_level",    level,    0);
    check("rst_af",       almost_full,  1'b0);
    check("rst_ae",       almost_empty, 1'b1);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Fill to capacity with 1..8, refuse a 9th, drain in order.
    for (int i = 1; i <= CAP; i++) drive(1'b1, DSIZE'(i), 1'b0, 1'b1);
    #1;
    check("fill_level",    level,    CAP);
    check("fill_wr_ready", wr_ready, 1'b0);
    drive(1'b1, 8'h09, 1'b0, 1'b1);
    #1;
    check("ninth_refused", level, CAP);
    for (int i = 1; i <= CAP; i++) begin
      #1;
      check("drain_data", rd_data, i);
      drive(1'b0, '0, 1'b1, 1'b1);
    end
    #1;
    check("drained_rd_valid", rd_valid, 1'b0);

    // Steady level of 3 with a write and a read every cycle, across a wrap.
    for (int i = 0; i < 3; i++) drive(1'b1, DSIZE'($urandom), 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, DSIZE'($urandom), 1'b1, 1'b1);
      #1;
      check("concurrent_level", level, 3);
    end

    // Clear beats a simultaneous write and read at level 5.
    for (int i = 0; i < 2; i++) drive(1'b1, DSIZE'($urandom), 1'b0, 1'b1);
    #1;
    check("pre_clear_level", level, 5);
    drive(1'b1, 8'hAA, 1'b1, 1'b0);
    #1;
    check("clear_level",    level,    0);
    check("clear_rd_valid", rd_valid, 1'b0);
    check("clear_wr_ready", wr_ready, 1'b1);

    // Asynchronous reset between edges at level 4.
    for (int i = 0; i < 4; i++) drive(1'b1, DSIZE'($urandom), 1'b0, 1'b1);
    wr_valid = 1'b0; rd_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_level",    level,        0);
    check("arst_wr_ready", wr_ready,     1'b1);
    check("arst_rd_valid", rd_valid,     1'b0);
    check("arst_af",       almost_full,  1'b0);
    check("arst_ae",       almost_empty, 1'b1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic in phases biased toward filling or draining.
    for (int ph = 0; ph < 12; ph++) begin
      int wp, rp;
      wp = (ph % 3 == 0) ? 85 : (ph % 3 == 1) ? 20 : 55;
      rp = (ph % 3 == 0) ? 20 : (ph % 3 == 1) ? 85 : 55;
      for (int i = 0; i < 200; i++)
        drive($urandom_range(99) < wp, DSIZE'($urandom), $urandom_range(99) < rp,
              $urandom_range(63) != 0);
    end

`ifdef LEVEL_FIFO_OVF_MON_EN
    // Saturating overflow counter, then clear.
    drive(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < CAP; i++) drive(1'b1, DSIZE'($urandom), 1'b0, 1'b1);
    for (int i = 0; i < 300; i++) drive(1'b1, DSIZE'($urandom), 1'b0, 1'b1);
    #1;
    check("ovf_flag_set",  ovf_flag,  1'b1);
    check("ovf_count_sat", ovf_count, 255);
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    check("ovf_flag_clr",  ovf_flag,  1'b0);
    check("ovf_count_clr", ovf_count, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/level_fifo.md
LEVEL_FIFO -- requirements
Module: level_fifo

Interface
REQ-001 SHALL have parameter ASIZE, default 5: address bits; capacity is exactly 2**ASIZE entries, all usable.
REQ-002 SHALL have parameter DSIZE, default 32: data width in bits.
REQ-003 SHALL have parameter AF_LEVEL, default 2**ASIZE-4: almost-full threshold, legal range 1..2**ASIZE.
REQ-004 SHALL have parameter AE_LEVEL, default 4: almost-empty threshold, legal range 0..2**ASIZE-1.
REQ-005 SHALL have port clk, input, 1: clock, rising edge; the only clock.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port clear_n, input, 1: synchronous clear, active-low.
REQ-008 SHALL have ports wr_data (input, DSIZE), wr_valid (input, 1) and wr_ready (output, 1): write handshake.
REQ-009 SHALL have ports rd_data (output, DSIZE), rd_valid (output, 1) and rd_ready (input, 1): read handshake.
REQ-010 SHALL have port level, output, ASIZE+1: current occupancy, 0..2**ASIZE.
REQ-011 SHALL have ports almost_full and almost_empty, outputs, 1 each: threshold flags.
REQ-012 SHALL have ports ovf_flag (output, 1) and ovf_count (output, 8) only when LEVEL_FIFO_OVF_MON_EN is defined.

Function
REQ-013 SHALL use ASIZE+1-bit read/write pointers; empty when the pointers are equal, full when the low ASIZE bits are equal and the MSBs differ.
REQ-014 SHALL drive wr_ready = !full and rd_valid = !empty, combinationally from registered pointers only (no input-to-output paths).
REQ-015 SHALL accept a write on a rising edge with wr_valid&&wr_ready: store wr_data at wr_ptr, then increment wr_ptr modulo 2**(ASIZE+1).
REQ-016 SHALL pop on a rising edge with rd_valid&&rd_ready: increment rd_ptr modulo 2**(ASIZE+1).
REQ-017 SHALL present rd_data = memory[rd_ptr] combinationally (first-word fall-through); rd_data is don't-care while rd_valid=0.
REQ-018 SHALL show write-to-read latency of 1 cycle: a word written into an empty FIFO at edge N gives rd_valid=1 after edge N.
REQ-019 SHALL perform simultaneous write and read when neither full nor empty, leaving level unchanged.
REQ-020 SHALL, when empty, not pop in the same cycle as a write (no bypass); when full, not write in the same cycle as a pop (wr_ready=0), so the write is accepted the next cycle.
REQ-021 SHALL keep level as a register updated with the handshakes: +1 on write only, -1 on read only, unchanged on both or neither; level always equals wr_ptr-rd_ptr.
REQ-022 SHALL drive almost_full = (level >= AF_LEVEL) and almost_empty = (level <= AE_LEVEL), derived from the registered level.
REQ-023 SHALL, on clear_n=0 at a rising edge, zero both pointers and level; clear takes priority over any handshake in that cycle, and the write in that cycle is discarded.
REQ-024 SHALL NOT reset or clear memory contents.

Reset
REQ-025 SHALL, while rst_n=0, hold wr_ptr=0, rd_ptr=0 and level=0, giving wr_ready=1, rd_valid=0, almost_full=0 and almost_empty=1, irrespective of clk.
REQ-026 SHALL discard all contents on reset asserted mid-operation, with normal operation from the first rising edge after deassertion.

Configuration
REQ-027 SHALL compile in overflow monitoring when LEVEL_FIFO_OVF_MON_EN is defined: each edge with wr_valid=1 and wr_ready=0 sets the sticky ovf_flag and increments ovf_count, saturating at 255.
REQ-028 SHALL clear ovf_flag and ovf_count to 0 on rst_n=0 or clear_n=0.
REQ-029 SHALL, without LEVEL_FIFO_OVF_MON_EN, omit ovf_flag, ovf_count and their logic entirely; all other behaviour is identical.

Verification
REQ-030 SHALL cover fill/drain: ASIZE=3 with 8 writes 0x01..0x08 and rd_ready=0 -> wr_ready=0 and level=8 after the 8th write; 9th write refused; drain returns 0x01..0x08 in order.
REQ-031 SHALL cover concurrent traffic: level=3 with write and read every cycle for 20 cycles -> level stays 3 and data is in order across the pointer wrap.
REQ-032 SHALL cover thresholds: ASIZE=3, AF_LEVEL=6, AE_LEVEL=1 -> almost_empty=1 for level 0..1 and almost_full=1 for level 6..8, checked on each edge.
REQ-033 SHALL cover clear priority: level=5 with clear_n=0 plus a simultaneous write and read -> next cycle level=0, rd_valid=0, wr_ready=1.
REQ-034 SHALL cover reset mid-operation: rst_n pulsed low between edges at level=4 -> outputs reach reset values immediately and level=0.
REQ-035 SHALL cover the macro-defined build: 300 writes attempted while full -> ovf_flag=1 and ovf_count=255; after clear_n=0 both read 0.
